// File: rtl/imm_ext_pkg.sv
// Shared mode encodings and default widths for the immediate/target generator.
package imm_ext_pkg;

    localparam logic [2:0] MODE_ZERO  = 3'd0;
    localparam logic [2:0] MODE_SIGN  = 3'd1;
    localparam logic [2:0] MODE_LUI   = 3'd2;
    localparam logic [2:0] MODE_BOFF  = 3'd3;
    localparam logic [2:0] MODE_BTGT  = 3'd4;
    localparam logic [2:0] MODE_JTGT  = 3'd5;
    localparam logic [2:0] MODE_SHAMT = 3'd6;
    localparam logic [2:0] MODE_ILL   = 3'd7;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_IMM_W  = 16;
    localparam int unsigned DEF_TGT_W  = 26;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational mode -> operand function: extensions, LUI placement, branch/jump targets, shamt.
module imm_ext_core import imm_ext_pkg::*; #(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned IMM_W   = DEF_IMM_W,
    parameter int unsigned TGT_W   = DEF_TGT_W,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic [2:0]        mode_i,
    input  logic [IMM_W-1:0]  imm_i,
    input  logic [TGT_W-1:0]  tgt_i,
    input  logic [DATA_W-1:0] npc_i,
    output logic [DATA_W-1:0] result_o
);

    localparam int unsigned LuiW = 2 * IMM_W;

    logic [LuiW-1:0]   lui_full;
    logic [DATA_W-1:0] zext;
    logic [DATA_W-1:0] sext;
    logic [DATA_W-1:0] lui;
    logic [DATA_W-1:0] boff;
    logic [DATA_W-1:0] hi_mask;
    logic [DATA_W-1:0] jtgt;
    logic [DATA_W-1:0] shamt;

    assign zext     = DATA_W'(imm_i);
    assign sext     = {{(DATA_W - IMM_W){imm_i[IMM_W-1]}}, imm_i};
    assign lui_full = {imm_i, {IMM_W{1'b0}}};
    assign lui      = DATA_W'(lui_full);
    assign boff     = sext << 2;
    // Keeps the PC region bits above the word-aligned target field.
    assign hi_mask  = {DATA_W{1'b1}} << (TGT_W + 2);
    assign jtgt     = (npc_i & hi_mask) | (DATA_W'(tgt_i) << 2);
    assign shamt    = DATA_W'(imm_i[SHAMT_W+5:6]);

    always_comb begin
        result_o = '0;
        case (mode_i)
            MODE_ZERO:  result_o = zext;
            MODE_SIGN:  result_o = sext;
            MODE_LUI:   result_o = lui;
            MODE_BOFF:  result_o = boff;
            MODE_BTGT:  result_o = npc_i + boff;
            MODE_JTGT:  result_o = jtgt;
            MODE_SHAMT: result_o = shamt;
            default:    result_o = '0;
        endcase
    end

endmodule

// File: rtl/imm_extend_unit.sv
// Buffered immediate/target generator: core function feeding a small result FIFO,
// with valid/ready handshakes on both sides and a sticky illegal-mode flag.
module imm_extend_unit import imm_ext_pkg::*; #(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned IMM_W   = DEF_IMM_W,
    parameter int unsigned TGT_W   = DEF_TGT_W,
    parameter int unsigned SHAMT_W = 5,
    parameter int unsigned DEPTH   = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               in_mode,
    input  logic [IMM_W-1:0]         in_imm,
    input  logic [TGT_W-1:0]         in_tgt,
    input  logic [DATA_W-1:0]        in_npc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [2:0]               out_mode,
    output logic                     err_illegal,
    input  logic                     err_clr,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [2:0]        mode_mem [DEPTH];

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            err_q, err_d;
    logic            push, pop;
    logic [DATA_W-1:0] result;

    imm_ext_core #(
        .DATA_W  (DATA_W),
        .IMM_W   (IMM_W),
        .TGT_W   (TGT_W),
        .SHAMT_W (SHAMT_W)
    ) u_core (
        .mode_i   (in_mode),
        .imm_i    (in_imm),
        .tgt_i    (in_tgt),
        .npc_i    (in_npc),
        .result_o (result)
    );

    assign out_valid = (count_q != '0);
    assign pop       = out_valid & out_ready;
    // A full FIFO still accepts when the head is popped in the same cycle.
    assign in_ready  = (count_q < CntW'(DEPTH)) | pop;
    assign push      = in_valid & in_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        err_d    = err_q;
        if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
        if (push && !pop)      count_d = count_q + CntW'(1);
        else if (pop && !push) count_d = count_q - CntW'(1);
        if (err_clr) err_d = 1'b0;
        if (push && (in_mode == MODE_ILL)) err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_q] <= result;
            mode_mem[wr_ptr_q] <= in_mode;
        end
    end

    // Storage is never reset, so an empty FIFO presents zeros rather than stale contents.
    assign out_data    = out_valid ? data_mem[rd_ptr_q] : '0;
    assign out_mode    = out_valid ? mode_mem[rd_ptr_q] : '0;
    assign level       = count_q;
    assign err_illegal = err_q;

endmodule
